// File: rtl/operand_fetch_pkg.sv
// ============================================================================
// operand_fetch_pkg : shared widths, FSM state type and hazard helpers
// Revision 1.0
// ============================================================================
`default_nettype none

package operand_fetch_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        OUT   = 2'd2
    } of_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] src1;
        logic [ADDR_W-1:0] src2;
        logic [ADDR_W-1:0] dest;
        logic              dest_en;
    } instr_t;

    // r0 never waits; a write landing this cycle satisfies the read through bypass
    function automatic logic src_ready(input logic [ADDR_W-1:0] r,
                                       input logic [NREGS-1:0]  pend,
                                       input logic              wb_en,
                                       input logic [ADDR_W-1:0] wb_dest);
        return (r == '0) || !pend[r] || (wb_en && (wb_dest == r));
    endfunction

    function automatic logic [DATA_W-1:0] operand_val(input logic [ADDR_W-1:0] r,
                                                      input logic [DATA_W-1:0] rd,
                                                      input logic              wb_en,
                                                      input logic [ADDR_W-1:0] wb_dest,
                                                      input logic [DATA_W-1:0] wb_data);
        if (r == '0)
            return '0;
        else if (wb_en && (wb_dest == r))
            return wb_data;
        else
            return rd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/operand_fetch_scoreboard.sv
// ============================================================================
// op_scoreboard : per-register write-pending bits; a set wins over a clear
// Revision 1.0
// ============================================================================
`default_nettype none

module op_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_i,
    input  logic [ADDR_W-1:0] set_idx_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] clr_idx_i,
    output logic [NREGS-1:0]  pending_o
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    always_comb begin
        pending_d = pending_q;
        if (clr_i)
            pending_d[clr_idx_i] = 1'b0;
        if (set_i)
            pending_d[set_idx_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            pending_q <= '0;
        else
            pending_q <= pending_d;
    end

    assign pending_o = pending_q;

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
// operand_fetch : issue-stage operand read with RAW/WAW stall and WB bypass
// Revision 1.0
// ============================================================================
`default_nettype none

module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [ADDR_W-1:0] iss_src1,
    input  logic [ADDR_W-1:0] iss_src2,
    input  logic [ADDR_W-1:0] iss_dest,
    input  logic              iss_dest_en,
    output logic [ADDR_W-1:0] rd_addr_1,
    output logic [ADDR_W-1:0] rd_addr_2,
    input  logic [DATA_W-1:0] rd_data_1,
    input  logic [DATA_W-1:0] rd_data_2,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [ADDR_W-1:0] op_dest,
    output logic              op_dest_en
);

    of_state_e         state_q, state_d;
    instr_t            held_q, held_d;
    instr_t            cand;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [ADDR_W-1:0] op_dest_q, op_dest_d;
    logic              op_dest_en_q, op_dest_en_d;
    logic [NREGS-1:0]  pending;
    logic              waw;
    logic              hazard;
    logic              accept;
    logic              evaluate;
    logic              capture;
    logic              set_en;

    // A stalled instruction keeps being evaluated from its latched copy
    always_comb begin
        if (state_q == STALL) begin
            cand = held_q;
        end else begin
            cand.src1    = iss_src1;
            cand.src2    = iss_src2;
            cand.dest    = iss_dest;
            cand.dest_en = iss_dest_en;
        end
    end

    assign rd_addr_1 = cand.src1;
    assign rd_addr_2 = cand.src2;

    assign iss_ready = rst && ((state_q == IDLE) || ((state_q == OUT) && op_ready));
    assign accept    = iss_valid && iss_ready;

    assign waw    = cand.dest_en && (cand.dest != '0) && pending[cand.dest]
                    && !(wb_en && (wb_dest == cand.dest));
    assign hazard = !src_ready(cand.src1, pending, wb_en, wb_dest)
                    || !src_ready(cand.src2, pending, wb_en, wb_dest)
                    || waw;

    assign evaluate = accept || (state_q == STALL);
    assign capture  = evaluate && !hazard;
    assign set_en   = capture && cand.dest_en && (cand.dest != '0);

    always_comb begin
        state_d      = state_q;
        held_d       = held_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_dest_d    = op_dest_q;
        op_dest_en_d = op_dest_en_q;
        case (state_q)
            IDLE, STALL, OUT: begin
                if (evaluate) begin
                    if (hazard) begin
                        state_d = STALL;
                        held_d  = cand;
                    end else begin
                        state_d      = OUT;
                        op_a_d       = operand_val(cand.src1, rd_data_1, wb_en, wb_dest, wb_data);
                        op_b_d       = operand_val(cand.src2, rd_data_2, wb_en, wb_dest, wb_data);
                        op_dest_d    = cand.dest;
                        op_dest_en_d = cand.dest_en;
                    end
                end else if ((state_q == OUT) && op_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            held_q       <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_dest_q    <= '0;
            op_dest_en_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            held_q       <= held_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_dest_q    <= op_dest_d;
            op_dest_en_q <= op_dest_en_d;
        end
    end

    op_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_i     (set_en),
        .set_idx_i (cand.dest),
        .clr_i     (wb_en),
        .clr_idx_i (wb_dest),
        .pending_o (pending)
    );

    assign op_valid   = (state_q == OUT);
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign op_dest    = op_dest_q;
    assign op_dest_en = op_dest_en_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
// tb_operand_fetch : directed cycle table plus random run against a model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_operand_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic       iss_valid;
    logic       iss_ready;
    logic [2:0] iss_src1, iss_src2, iss_dest;
    logic       iss_dest_en;
    logic [2:0] rd_addr_1, rd_addr_2;
    logic [7:0] rd_data_1, rd_data_2;
    logic       wb_en;
    logic [2:0] wb_dest;
    logic [7:0] wb_data;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] op_a, op_b;
    logic [2:0] op_dest;
    logic       op_dest_en;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_dest(iss_dest), .iss_dest_en(iss_dest_en),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_dest(op_dest), .op_dest_en(op_dest_en)
    );

    // Environment register file: r_i starts at 0x11*i, r0 always reads 0
    logic [7:0] regs [8];
    logic       env_init = 1'b0;

    always @(posedge clk) begin
        if (!env_init) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'(i * 17);
        end else if (wb_en && wb_dest != 3'd0) begin
            regs[wb_dest] <= wb_data;
        end
    end

    assign rd_data_1 = (rd_addr_1 == 3'd0) ? 8'h00 : regs[rd_addr_1];
    assign rd_data_2 = (rd_addr_2 == 3'd0) ? 8'h00 : regs[rd_addr_2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit iv, input bit [2:0] s1, input bit [2:0] s2,
                         input bit [2:0] d, input bit de, input bit we, input bit [2:0] wd,
                         input bit [7:0] wdat, input bit ordy);
        rst = r; iss_valid = iv; iss_src1 = s1; iss_src2 = s2; iss_dest = d;
        iss_dest_en = de; wb_en = we; wb_dest = wd; wb_data = wdat; op_ready = ordy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_iss_ready", iss_ready, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_op_dest", op_dest, 0);
        chk("rst_op_dest_en", op_dest_en, 0);
    endtask

    typedef struct {
        bit       rst_n, iv;
        bit [2:0] s1, s2, d;
        bit       de, we;
        bit [2:0] wd;
        bit [7:0] wdat;
        bit       ordy;
        bit       e_irdy, e_ov;
        bit [7:0] e_a, e_b;
        bit [2:0] e_dest, e_ad1;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rn, input bit iv, input bit [2:0] s1, input bit [2:0] s2,
                       input bit [2:0] d, input bit de, input bit we, input bit [2:0] wd,
                       input bit [7:0] wdat, input bit ordy, input bit e_irdy, input bit e_ov,
                       input bit [7:0] e_a, input bit [7:0] e_b, input bit [2:0] e_dest,
                       input bit [2:0] e_ad1);
        vec_t v;
        v = '{rn, iv, s1, s2, d, de, we, wd, wdat, ordy, e_irdy, e_ov, e_a, e_b, e_dest, e_ad1};
        tbl.push_back(v);
    endtask

    // Behavioural model state for the random phase
    bit       m_out, m_held;
    bit [7:0] m_pend;
    bit [2:0] h_s1, h_s2, h_d;
    bit       h_de;
    bit [7:0] o_a, o_b;
    bit [2:0] o_d;
    bit       o_de;

    function automatic bit m_rdy(input bit [2:0] r);
        return (r == 0) || !m_pend[r] || (wb_en && wb_dest == r);
    endfunction

    function automatic bit [7:0] m_val(input bit [2:0] r);
        if (r == 0) return 8'h00;
        if (wb_en && wb_dest == r) return wb_data;
        return regs[r];
    endfunction

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // rst,iv,s1,s2,d,de, we,wd,wdat, ordy | irdy,ov,a,b,dest,rd_addr_1
        add(1,1,1,2,5,1, 0,0,8'h00, 1,  1,0,8'h00,8'h00,0,1);
        add(1,0,1,2,5,1, 0,0,8'h00, 0,  0,1,8'h11,8'h22,5,1);
        add(1,0,1,2,5,1, 0,0,8'h00, 0,  0,1,8'h11,8'h22,5,1);
        add(1,0,1,2,5,1, 0,0,8'h00, 0,  0,1,8'h11,8'h22,5,1);
        add(1,0,1,2,5,1, 0,0,8'h00, 1,  1,1,8'h11,8'h22,5,1);
        add(1,0,0,0,0,0, 1,5,8'h55, 1,  1,0,8'h00,8'h00,0,0);
        add(1,1,0,0,3,1, 0,0,8'h00, 1,  1,0,8'h00,8'h00,0,0);
        add(1,0,0,0,0,0, 0,0,8'h00, 1,  1,1,8'h00,8'h00,3,0);
        add(1,1,3,1,0,0, 0,0,8'h00, 1,  1,0,8'h00,8'h00,0,3);
        add(1,0,7,7,0,0, 0,0,8'h00, 1,  0,0,8'h00,8'h00,0,3);
        add(1,0,7,7,0,0, 1,3,8'hA5, 1,  0,0,8'h00,8'h00,0,3);
        add(1,1,3,3,0,0, 0,0,8'h00, 1,  1,1,8'hA5,8'h11,0,3);
        add(1,1,0,0,0,1, 0,0,8'h00, 1,  1,1,8'hA5,8'hA5,0,0);
        add(1,1,0,2,0,0, 0,0,8'h00, 1,  1,1,8'h00,8'h00,0,0);
        add(1,1,1,1,4,1, 0,0,8'h00, 1,  1,1,8'h00,8'h22,0,1);
        add(1,1,2,2,4,1, 0,0,8'h00, 1,  1,1,8'h11,8'h11,4,2);
        add(1,0,6,6,0,0, 0,0,8'h00, 1,  0,0,8'h00,8'h00,0,2);
        add(1,0,6,6,0,0, 1,4,8'h4F, 1,  0,0,8'h00,8'h00,0,2);
        add(1,1,4,0,0,0, 0,0,8'h00, 1,  1,1,8'h22,8'h22,4,4);
        add(1,0,6,6,0,0, 0,0,8'h00, 1,  0,0,8'h00,8'h00,0,4);
        add(0,0,6,6,0,0, 0,0,8'h00, 1,  0,0,8'h00,8'h00,0,4);
        add(1,1,4,0,0,0, 0,0,8'h00, 1,  1,0,8'h00,8'h00,0,4);
        add(1,0,0,0,0,0, 0,0,8'h00, 1,  1,1,8'h4F,8'h00,0,0);

        do_reset();
        env_init = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].rst_n, tbl[i].iv, tbl[i].s1, tbl[i].s2, tbl[i].d, tbl[i].de,
                  tbl[i].we, tbl[i].wd, tbl[i].wdat, tbl[i].ordy);
            #1;
            chk($sformatf("vec%0d_iss_ready", i), iss_ready, tbl[i].e_irdy);
            chk($sformatf("vec%0d_op_valid", i), op_valid, tbl[i].e_ov);
            chk($sformatf("vec%0d_rd_addr_1", i), rd_addr_1, tbl[i].e_ad1);
            if (tbl[i].e_ov) begin
                chk($sformatf("vec%0d_op_a", i), op_a, tbl[i].e_a);
                chk($sformatf("vec%0d_op_b", i), op_b, tbl[i].e_b);
                chk($sformatf("vec%0d_op_dest", i), op_dest, tbl[i].e_dest);
            end
        end

        // Random phase against the model
        do_reset();
        m_out = 0; m_held = 0; m_pend = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit       r, iv, de, we, ordy, e_irdy, haz, take;
            bit [2:0] s1, s2, d, wd, c_s1, c_s2, c_d;
            bit       c_de;
            bit [7:0] va, vb;
            @(negedge clk);
            r    = ($urandom_range(0, 79) != 0);
            iv   = ($urandom_range(0, 9) < 7);
            s1   = 3'($urandom_range(0, 7));
            s2   = 3'($urandom_range(0, 7));
            d    = 3'($urandom_range(0, 7));
            de   = ($urandom_range(0, 9) < 6);
            we   = ($urandom_range(0, 9) < 4);
            ordy = ($urandom_range(0, 9) < 7);
            wd   = 3'($urandom_range(0, 7));
            if (m_pend != 0 && $urandom_range(0, 3) != 0) begin
                for (int k = 0; k < 64; k++) begin
                    wd = 3'($urandom_range(0, 7));
                    if (m_pend[wd]) break;
                end
            end
            drive(r, iv, s1, s2, d, de, we, wd, 8'($urandom_range(0, 255)), ordy);
            #1;
            e_irdy = r && ((!m_out && !m_held) || (m_out && ordy));
            c_s1 = m_held ? h_s1 : s1;
            c_s2 = m_held ? h_s2 : s2;
            c_d  = m_held ? h_d  : d;
            c_de = m_held ? h_de : de;
            chk("rnd_iss_ready", iss_ready, e_irdy);
            chk("rnd_op_valid", op_valid, m_out);
            chk("rnd_rd_addr_1", rd_addr_1, c_s1);
            chk("rnd_rd_addr_2", rd_addr_2, c_s2);
            if (m_out) begin
                chk("rnd_op_a", op_a, o_a);
                chk("rnd_op_b", op_b, o_b);
                chk("rnd_op_dest", op_dest, o_d);
                chk("rnd_op_dest_en", op_dest_en, o_de);
            end
            if (!r) begin
                m_out = 0; m_held = 0; m_pend = 0;
            end else begin
                haz  = !m_rdy(c_s1) || !m_rdy(c_s2)
                       || (c_de && c_d != 0 && m_pend[c_d] && !(we && wd == c_d));
                take = m_held || (iv && e_irdy);
                va   = m_val(c_s1);
                vb   = m_val(c_s2);
                if (we) m_pend[wd] = 1'b0;
                if (m_out && ordy) m_out = 0;
                if (take) begin
                    if (haz) begin
                        m_held = 1; h_s1 = c_s1; h_s2 = c_s2; h_d = c_d; h_de = c_de;
                    end else begin
                        m_held = 0; m_out = 1;
                        o_a = va; o_b = vb; o_d = c_d; o_de = c_de;
                        if (c_de && c_d != 0) m_pend[c_d] = 1'b1;
                    end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  synchronous active-low reset; sampled on posedge clk.
REQ-004 iss_valid/iss_ready  in/out  1/1  issue handshake; transfer when both are high at posedge.
REQ-005 iss_src1, iss_src2, iss_dest  in  3 each  source and destination register numbers.
REQ-006 iss_dest_en  in  1  instruction writes iss_dest.
REQ-007 rd_addr_1/rd_addr_2  out  3/3  register-file read addresses; combinational.
REQ-008 rd_data_1/rd_data_2  in  8/8  register-file read data; combinational and same-cycle; r0 reads 0.
REQ-009 wb_en, wb_dest, wb_data  in  1/3/8  writeback port, the same signals that drive the register-file write port.
REQ-010 op_valid/op_ready  out/in  1/1  operand output handshake.
REQ-011 op_a, op_b  out  8/8  captured operands; op_dest out 3; op_dest_en out 1.

Function
REQ-012 States: IDLE (no instruction held), STALL (instruction held, hazard pending) and OUT (operands valid).
REQ-013 iss_ready SHALL be 1 in IDLE, op_ready in OUT, and 0 in STALL and while rst=0.
REQ-014 pending[7:0] scoreboard: a bit is set when an instruction with dest_en=1 and dest!=0 enters OUT, and cleared when wb_en=1 with wb_dest equal to that bit.
REQ-015 Simultaneous set and clear of the same pending bit SHALL result in set.
REQ-016 A source is ready if it is 0, or its pending bit is clear, or wb_en=1 with wb_dest equal to that source in the current cycle (bypass).
REQ-017 Hazard = src1 not ready, or src2 not ready, or (dest_en=1 and dest!=0 and pending[dest]=1 with no same-cycle clearing wb).
REQ-018 rd_addr_1/2 SHALL equal iss_src1/2 in IDLE and OUT, and equal the latched sources in STALL.
REQ-019 Operand value SHALL be 0 for r0, wb_data when the bypass of REQ-016 applies, and rd_data otherwise.
REQ-020 On acceptance without hazard: capture operands, dest and dest_en; go to OUT; op_valid=1 the next cycle (latency 1).
REQ-021 On acceptance with hazard: latch src1, src2, dest and dest_en; go to STALL.
REQ-022 In STALL, re-evaluate the hazard every cycle; when it is clear, capture operands and go to OUT.
REQ-023 In OUT, if op_ready=0, hold all op_* outputs stable.
REQ-024 In OUT, if op_ready=1 and iss_valid=0, go to IDLE.
REQ-025 In OUT, if op_ready=1 and iss_valid=1, accept back-to-back per REQ-020/021; the hazard check SHALL include the pending bit set by the departing instruction.
REQ-026 Throughput SHALL be 1 instruction/cycle when there are no hazards.

Reset
REQ-027 When rst=0 at posedge: state=IDLE, pending=0, op_valid=0, op_a=op_b=0, op_dest=0, op_dest_en=0, and latched sources=0.
REQ-028 Reset mid-operation SHALL discard held and output instructions; wb_en during reset SHALL be ignored.

Structure
REQ-029 A shared package SHALL hold DATA_W=8, ADDR_W=3, NREGS=8 and the state enum {IDLE, STALL, OUT}.
REQ-030 The scoreboard SHALL be one sub-module, op_scoreboard, providing set/clear ports and a pending vector output.

Verification
REQ-031 Reset, then issue src1=1, src2=2 (regfile r1=0x11, r2=0x22) -> op_valid next cycle, op_a=0x11, op_b=0x22.
REQ-032 Issue dest=3 and drain it, then issue src1=3 -> STALL; wb_en, wb_dest=3, wb_data=0xA5 -> same-cycle capture, op_a=0xA5, pending[3]=0.
REQ-033 Issue dest=0, then src1=0 -> no stall, op_a=0, pending stays 0.
REQ-034 op_ready=0 for 3 cycles in OUT -> op_* stable, iss_ready=0; op_ready=1 with iss_valid=1 -> back-to-back accept.
REQ-035 Issue dest=4 twice with no writeback -> second instruction stalls on WAW until wb_dest=4; simultaneous clear/set leaves pending[4]=1.
REQ-036 Drive rst=0 while in STALL -> next cycle IDLE, op_valid=0, pending=0.
